fft_reorder: RTL and testbench
==============================

FFT_REORDER -- requirements
Module: fft_reorder

Interface
REQ-001 Parameter: WIDTH, 16, bit width of each real/imag sample.
REQ-002 Parameter: N, 64, frame length in samples; power of two; LOG2N = log2(N).
REQ-003 clock  input  1  master clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 di_en  input  1  input sample valid; one sample per cycle when high.
REQ-006 di_re  input  WIDTH  input real part, bit-reversed frame order.
REQ-007 di_im  input  WIDTH  input imag part, bit-reversed frame order.
REQ-008 do_en  output 1  output sample valid.
REQ-009 do_re  output WIDTH  output real part, natural order.
REQ-010 do_im  output WIDTH  output imag part, natural order.
REQ-011 do_sof  output 1  first sample of output frame (present only with FFT_REORDER_SOF_EN).

Function
REQ-012 Block SHALL convert frames of N samples from bit-reversed order (as emitted by the team's FFT) to natural order; data values pass unchanged (no arithmetic, no rounding).
REQ-013 Storage SHALL be two banks (ping-pong) of N entries x 2*WIDTH bits.
REQ-014 Write side: counter wcnt (LOG2N bits) advances only on cycles with di_en=1; sample written to active write bank at address bitrev(wcnt) (e.g. wcnt=1 -> addr 32, wcnt=6 -> addr 24 for N=64).
REQ-015 Gaps in di_en SHALL be tolerated; wcnt and bank selection hold during gaps.
REQ-016 When wcnt wraps N-1 -> 0, current write bank SHALL be marked full and write bank SHALL toggle.
REQ-017 Read side: states IDLE, READ. IDLE -> READ on the cycle after a bank becomes full; READ reads that bank at addresses 0..N-1, one per cycle, no gaps.
REQ-018 READ -> IDLE after address N-1 unless the other bank is full at that cycle, in which case READ continues directly with the other bank at address 0 (back-to-back frames with no bubble).
REQ-019 Bank full flag SHALL clear on the cycle its address N-1 is read; simultaneous set (other bank) and clear SHALL both take effect.
REQ-020 do_en, do_re, do_im SHALL be registered; do_re/do_im hold last value when do_en=0.
REQ-021 Latency: first output sample valid (do_en=1) on the 2nd rising edge after the edge sampling the frame's last input; with continuous input, N+1 cycles from first input to first output.
REQ-022 Overrun cannot occur under the one-sample-per-cycle input rule; no back-pressure port exists.

Reset
REQ-023 reset SHALL set wcnt=0, write bank=0, both full flags=0, read state IDLE, read address 0.
REQ-024 reset SHALL force do_en=0, do_re=0, do_im=0 (and do_sof=0) on the next edge.
REQ-025 Reset mid-frame SHALL discard partial input and any unread frame; memory contents need not be cleared.

Configuration
REQ-026 Macro FFT_REORDER_SOF_EN defined: port do_sof exists, asserted with do_en for exactly the address-0 sample of each output frame, 0 otherwise.
REQ-027 Macro undefined: port do_sof absent; all other behaviour identical.

Structure
REQ-028 Shared package fft_pkg SHALL hold N, LOG2N, WIDTH defaults and the bitrev function.
REQ-029 Sub-module fft_reorder_bank: N x 2*WIDTH simple dual-port RAM, one write and one registered read port; instantiated twice.

Verification
REQ-030 Continuous frame of values k at bit-reversed index bitrev(k), k=0..63 -> do_en high 64 cycles starting 65 cycles after first input, do_re=0,1,...,63 in order.
REQ-031 Three frames back-to-back -> 192 consecutive do_en cycles, no bubble, each frame in natural order.
REQ-032 Input with di_en gaps (1 on, 2 off) -> output frame unchanged in content; do_en contiguous 64 cycles starting 2 cycles after last input.
REQ-033 reset asserted after 20 inputs, then full frame -> outputs 0 during/after reset, only the new frame emitted, correct order.
REQ-034 FFT_REORDER_SOF_EN defined, two frames -> do_sof high exactly twice, coinciding with do_re=0 samples.
REQ-035 Chain FFT -> fft_reorder with impulse at sample 0 (value 64) -> all 64 outputs equal 1 in natural order.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: defaults and helpers shared by the FFT reorder slice.
//   WIDTH  - default bit width of each real/imag sample
//   N      - default frame length (power of two)
//   LOG2N  - address width for one frame
//   rd_state_t - read-side FSM encoding
//   bitrev - reverse the low 'bits' bits of a value
package fft_pkg;

  localparam int WIDTH = 16;
  localparam int N     = 64;
  localparam int LOG2N = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

  // Shift-based so the loop index never appears as a bit-select.
  function automatic logic [31:0] bitrev(input logic [31:0] a, input int bits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < bits) r = r | (((a >> i) & 32'd1) << (bits - 1 - i));
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// fft_reorder_bank: N x DW simple dual-port RAM for one ping-pong bank.
//   clock        - rising-edge clock
//   we/waddr/wdata - write port
//   re/raddr     - read request; rdata is registered and holds when re=0
//   rdata        - read data, one cycle after the request
module fft_reorder_bank #(
  parameter int DW = 32,
  parameter int N  = 64,
  parameter int AW = $clog2(N)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  import fft_pkg::*;

  logic [DW-1:0] mem [N];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_reorder.sv
// fft_reorder: converts frames of N complex samples from bit-reversed order
// to natural order using two ping-pong banks.
//   clock, reset        - rising-edge clock, synchronous active-high reset
//   di_en, di_re, di_im - input samples, bit-reversed frame order
//   do_en, do_re, do_im - output samples, natural order (registered)
//   do_sof              - first sample of each output frame; exists only when
//                         FFT_REORDER_SOF_EN is defined
module fft_reorder #(
  parameter int WIDTH = fft_pkg::WIDTH,
  parameter int N     = fft_pkg::N
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im
`ifdef FFT_REORDER_SOF_EN
  ,
  output logic             do_sof
`endif
);
  import fft_pkg::*;

  localparam int AW     = $clog2(N);
  localparam int DW     = 2 * WIDTH;
  localparam int STAGES = 2;  // RAM read register, output register

  // ---------------- write side ----------------
  logic [AW-1:0] wcnt;
  logic          wbank;
  logic [1:0]    full;
  logic [AW-1:0] waddr;
  logic          wr_last;

  assign waddr   = AW'(bitrev(32'(wcnt), AW));
  assign wr_last = di_en && (wcnt == AW'(N - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      wcnt  <= '0;
      wbank <= 1'b0;
    end else if (di_en) begin
      wcnt <= wcnt + AW'(1);
      if (wr_last) wbank <= ~wbank;
    end
  end

  // ---------------- read side ----------------
  rd_state_t     state, state_nxt;
  logic [AW-1:0] raddr, raddr_nxt;
  logic          rbank, rbank_nxt;
  logic [1:0]    full_clr, full_set;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          other_ready;

  // The read of address 0 is issued in the cycle the full flag is first
  // seen, so the last address of a frame is issued one cycle before the
  // following frame's full flag becomes visible. Looking at the write that
  // completes that frame keeps back-to-back frames bubble-free.
  assign other_ready = full[~rbank] || (wr_last && (wbank != rbank));

  always_comb begin
    state_nxt = state;
    raddr_nxt = raddr;
    rbank_nxt = rbank;
    rd_en     = 1'b0;
    rd_addr   = raddr;
    full_clr  = 2'b00;
    case (state)
      IDLE: begin
        if (full[rbank]) begin
          rd_en     = 1'b1;
          rd_addr   = '0;
          raddr_nxt = AW'(1);
          state_nxt = READ;
        end
      end
      READ: begin
        rd_en = 1'b1;
        if (raddr == AW'(N - 1)) begin
          full_clr[rbank] = 1'b1;
          rbank_nxt       = ~rbank;
          raddr_nxt       = '0;
          if (!other_ready) state_nxt = IDLE;
        end else begin
          raddr_nxt = raddr + AW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    full_set        = 2'b00;
    full_set[wbank] = wr_last;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      raddr <= '0;
      rbank <= 1'b0;
      full  <= 2'b00;
    end else begin
      state <= state_nxt;
      raddr <= raddr_nxt;
      rbank <= rbank_nxt;
      full  <= (full & ~full_clr) | full_set;
    end
  end

  // ---------------- banks ----------------
  logic [1:0][DW-1:0] rdata;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_reorder_bank #(.DW(DW), .N(N), .AW(AW)) u_bank (
      .clock (clock),
      .we    (di_en && (wbank == 1'(b))),
      .waddr (waddr),
      .wdata ({di_re, di_im}),
      .re    (rd_en && (rbank == 1'(b))),
      .raddr (rd_addr),
      .rdata (rdata[b])
    );
  end

  // ---------------- output pipeline ----------------
  logic [STAGES-1:0] vld_pipe;
  logic [STAGES-1:0] sof_pipe;
  logic              bank_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      sof_pipe <= '0;
      bank_d   <= 1'b0;
      do_re    <= '0;
      do_im    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], rd_en};
      sof_pipe <= {sof_pipe[STAGES-2:0], rd_en && (rd_addr == '0)};
      if (rd_en) bank_d <= rbank;
      if (vld_pipe[0]) {do_re, do_im} <= rdata[bank_d];
    end
  end

  assign do_en = vld_pipe[STAGES-1];

`ifdef FFT_REORDER_SOF_EN
  assign do_sof = sof_pipe[STAGES-1];
`else
  logic unused_sof;
  assign unused_sof = sof_pipe[STAGES-1];
`endif

endmodule

// File: tb/tb_fft_reorder.sv
// tb_fft_reorder: scoreboard bench for fft_reorder (N=64, WIDTH=16).
// Expected natural-order samples are queued as frames are driven; a negedge
// monitor records every do_en sample with its cycle stamp, and each test
// task compares the recorded samples against the queue.
// Build with FFT_REORDER_SOF_EN defined to also check do_sof.
module tb_fft_reorder;
  localparam int W = 16;
  localparam int N = 64;

  logic         clock = 1'b0;
  logic         reset;
  logic         di_en;
  logic [W-1:0] di_re, di_im;
  logic         do_en;
  logic [W-1:0] do_re, do_im;
  logic         sof_obs;
`ifdef FFT_REORDER_SOF_EN
  logic         do_sof;
  assign sof_obs = do_sof;
`else
  assign sof_obs = 1'b0;
`endif

  fft_reorder #(.WIDTH(W), .N(N)) dut (
    .clock (clock),
    .reset (reset),
    .di_en (di_en),
    .di_re (di_re),
    .di_im (di_im),
    .do_en (do_en),
    .do_re (do_re),
    .do_im (do_im)
`ifdef FFT_REORDER_SOF_EN
    ,
    .do_sof(do_sof)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         sof;
  } obs_t;

  obs_t obs[$];
  always @(negedge clock) begin
    if (do_en === 1'b1) begin
      obs_t o;
      o.cyc = cyc;
      o.re  = do_re;
      o.im  = do_im;
      o.sof = sof_obs;
      obs.push_back(o);
    end
  end

  logic [2*W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int rd_ptr = 0;

  function automatic logic [5:0] brev(input logic [5:0] a);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[5-i] = a[i];
    return r;
  endfunction

  task automatic drive(input logic en, input logic [W-1:0] re, input logic [W-1:0] im);
    di_en = en;
    di_re = re;
    di_im = im;
    @(posedge clock);
    #1;
  endtask

  // Natural-order frame re[k] = base + step*k is driven in bit-reversed
  // order, with 'gap' idle cycles after every sample.
  task automatic send_frame(input int base, input int step, input int gap,
                            output int first_edge, output int last_edge);
    logic [W-1:0] nre[N];
    logic [W-1:0] nim[N];
    first_edge = 0;
    last_edge  = 0;
    for (int k = 0; k < N; k++) begin
      nre[k] = W'(base + step * k);
      nim[k] = (step == 0) ? '0 : W'($urandom);
      exp_q.push_back({nre[k], nim[k]});
    end
    for (int j = 0; j < N; j++) begin
      logic [5:0] a;
      a = brev(6'(j));
      drive(1'b1, nre[a], nim[a]);
      if (j == 0) first_edge = cyc;
      last_edge = cyc;
      for (int g = 0; g < gap; g++) drive(1'b0, W'($urandom), W'($urandom));
    end
    di_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(2);
    @(negedge clock);
    checks++;
    if (do_en !== 1'b0 || do_re !== '0 || do_im !== '0 || sof_obs !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b re=%h im=%h sof=%b, want all 0",
               do_en, do_re, do_im, sof_obs);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(5);
    checks++;
    if (obs.size() != 0) begin
      errors++;
      $display("FAIL reset_idle: got %0d outputs, want 0", obs.size());
    end
  endtask

  task automatic test_single_frame;
    int fe, le, t;
    send_frame(0, 1, 0, fe, le);
    for (t = 0; t < 300 && obs.size() < rd_ptr + N; t++) idle(1);
    checks++;
    if (obs.size() < rd_ptr + N) begin
      errors++;
      $display("FAIL single_timeout: got %0d outputs, want %0d", obs.size() - rd_ptr, N);
      exp_q.delete();
      rd_ptr = obs.size();
      return;
    end
    checks++;
    if (obs[rd_ptr].cyc != fe + N + 1) begin
      errors++;
      $display("FAIL single_latency: got edge %0d, want %0d", obs[rd_ptr].cyc, fe + N + 1);
    end
    for (int i = 0; i < N; i++) begin
      logic [2*W-1:0] e;
      obs_t o;
      e = exp_q.pop_front();
      o = obs[rd_ptr + i];
      checks++;
      if ({o.re, o.im} !== e || o.re !== W'(i)) begin
        errors++;
        $display("FAIL single_data[%0d]: got %h, want %h", i, {o.re, o.im}, e);
      end
      if (i > 0) begin
        checks++;
        if (o.cyc != obs[rd_ptr + i - 1].cyc + 1) begin
          errors++;
          $display("FAIL single_contig[%0d]: got edge %0d, want %0d", i, o.cyc,
                   obs[rd_ptr + i - 1].cyc + 1);
        end
      end
`ifdef FFT_REORDER_SOF_EN
      checks++;
      if (o.sof !== (i == 0)) begin
        errors++;
        $display("FAIL single_sof[%0d]: got %b, want %b", i, o.sof, i == 0);
      end
`endif
    end
    rd_ptr += N;
    idle(10);
    checks++;
    if (obs.size() != rd_ptr) begin
      errors++;
      $display("FAIL single_extra: got %0d outputs, want %0d", obs.size(), rd_ptr);
    end
  endtask

  task automatic test_back_to_back;
    int fe, le, fe0, t, nsof;
    send_frame(100, 1, 0, fe0, le);
    send_frame(1000, 3, 0, fe, le);
    send_frame(5000, 7, 0, fe, le);
    for (t = 0; t < 600 && obs.size() < rd_ptr + 3 * N; t++) idle(1);
    checks++;
    if (obs.size() < rd_ptr + 3 * N) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d outputs, want %0d", obs.size() - rd_ptr, 3 * N);
      exp_q.delete();
      rd_ptr = obs.size();
      return;
    end
    checks++;
    if (obs[rd_ptr].cyc != fe0 + N + 1) begin
      errors++;
      $display("FAIL b2b_latency: got edge %0d, want %0d", obs[rd_ptr].cyc, fe0 + N + 1);
    end
    nsof = 0;
    for (int i = 0; i < 3 * N; i++) begin
      logic [2*W-1:0] e;
      obs_t o;
      e = exp_q.pop_front();
      o = obs[rd_ptr + i];
      if (o.sof) nsof++;
      checks++;
      if ({o.re, o.im} !== e) begin
        errors++;
        $display("FAIL b2b_data[%0d]: got %h, want %h", i, {o.re, o.im}, e);
      end
      if (i > 0) begin
        checks++;
        if (o.cyc != obs[rd_ptr + i - 1].cyc + 1) begin
          errors++;
          $display("FAIL b2b_contig[%0d]: got edge %0d, want %0d", i, o.cyc,
                   obs[rd_ptr + i - 1].cyc + 1);
        end
      end
    end
`ifdef FFT_REORDER_SOF_EN
    checks++;
    if (nsof != 3) begin
      errors++;
      $display("FAIL b2b_sof_count: got %0d, want 3", nsof);
    end
`endif
    rd_ptr += 3 * N;
    idle(10);
  endtask

  task automatic test_gaps;
    int fe, le, t;
    send_frame(300, 2, 2, fe, le);
    for (t = 0; t < 300 && obs.size() < rd_ptr + N; t++) idle(1);
    checks++;
    if (obs.size() < rd_ptr + N) begin
      errors++;
      $display("FAIL gaps_timeout: got %0d outputs, want %0d", obs.size() - rd_ptr, N);
      exp_q.delete();
      rd_ptr = obs.size();
      return;
    end
    checks++;
    if (obs[rd_ptr].cyc != le + 2) begin
      errors++;
      $display("FAIL gaps_latency: got edge %0d, want %0d", obs[rd_ptr].cyc, le + 2);
    end
    for (int i = 0; i < N; i++) begin
      logic [2*W-1:0] e;
      obs_t o;
      e = exp_q.pop_front();
      o = obs[rd_ptr + i];
      checks++;
      if ({o.re, o.im} !== e || o.cyc != obs[rd_ptr].cyc + i) begin
        errors++;
        $display("FAIL gaps_data[%0d]: got %h at edge %0d, want %h at edge %0d",
                 i, {o.re, o.im}, o.cyc, e, obs[rd_ptr].cyc + i);
      end
`ifdef FFT_REORDER_SOF_EN
      checks++;
      if (o.sof !== (i == 0)) begin
        errors++;
        $display("FAIL gaps_sof[%0d]: got %b, want %b", i, o.sof, i == 0);
      end
`endif
    end
    rd_ptr += N;
    idle(10);
  endtask

  task automatic test_reset_mid_frame;
    int fe, le, t;
    for (int j = 0; j < 20; j++) drive(1'b1, W'(16'hdead + j), W'(j));
    di_en = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    checks++;
    if (do_en !== 1'b0 || do_re !== '0 || do_im !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got en=%b re=%h im=%h, want all 0", do_en, do_re, do_im);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(3);
    checks++;
    if (do_re !== '0 || obs.size() != rd_ptr) begin
      errors++;
      $display("FAIL rst_mid_after: got re=%h outputs=%0d, want re=0 outputs=%0d",
               do_re, obs.size(), rd_ptr);
    end
    send_frame(700, 5, 0, fe, le);
    for (t = 0; t < 300 && obs.size() < rd_ptr + N; t++) idle(1);
    idle(10);
    checks++;
    if (obs.size() != rd_ptr + N) begin
      errors++;
      $display("FAIL rst_mid_count: got %0d outputs, want %0d", obs.size() - rd_ptr, N);
      exp_q.delete();
      rd_ptr = obs.size();
      return;
    end
    for (int i = 0; i < N; i++) begin
      logic [2*W-1:0] e;
      obs_t o;
      e = exp_q.pop_front();
      o = obs[rd_ptr + i];
      checks++;
      if ({o.re, o.im} !== e) begin
        errors++;
        $display("FAIL rst_mid_data[%0d]: got %h, want %h", i, {o.re, o.im}, e);
      end
    end
    rd_ptr += N;
  endtask

  // Spectrum of a 64-valued impulse at sample 0 is a flat 1 in every bin,
  // which the FFT emits in bit-reversed order.
  task automatic test_impulse;
    int fe, le, t;
    send_frame(1, 0, 0, fe, le);
    for (t = 0; t < 300 && obs.size() < rd_ptr + N; t++) idle(1);
    checks++;
    if (obs.size() < rd_ptr + N) begin
      errors++;
      $display("FAIL impulse_timeout: got %0d outputs, want %0d", obs.size() - rd_ptr, N);
      exp_q.delete();
      rd_ptr = obs.size();
      return;
    end
    for (int i = 0; i < N; i++) begin
      obs_t o;
      void'(exp_q.pop_front());
      o = obs[rd_ptr + i];
      checks++;
      if (o.re !== W'(1) || o.im !== '0) begin
        errors++;
        $display("FAIL impulse[%0d]: got re=%h im=%h, want re=1 im=0", i, o.re, o.im);
      end
    end
    rd_ptr += N;
    idle(5);
  endtask

  initial begin
    reset = 1'b1;
    di_en = 1'b0;
    di_re = '0;
    di_im = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gaps();
    test_reset_mid_frame();
    test_impulse();
    checks++;
    if (exp_q.size() != 0 || obs.size() != rd_ptr) begin
      errors++;
      $display("FAIL final_drain: got %0d pending, %0d outputs, want 0 pending, %0d outputs",
               exp_q.size(), obs.size(), rd_ptr);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
